// File: rtl/bsg_div_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bsg_div_pkg : shared state encoding and constants for the iterative divider
// Rev 1.0
// ----------------------------------------------------------------------------
package bsg_div_pkg;

  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eCALC = 2'd1,
    eFIX  = 2'd2,
    eDONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_MAX_WIDTH = 64;

  // All-ones pattern of the requested width, the quotient produced by x/0.
  function automatic logic [DIV_MAX_WIDTH-1:0] div_by_zero_quotient(input int unsigned width);
    logic [DIV_MAX_WIDTH-1:0] q;
    q = '0;
    for (int unsigned i = 0; i < DIV_MAX_WIDTH; i++) begin
      q[i] = (i < width);
    end
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_div_iterative_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bsg_div_iterative_step : one restoring-division step (shift in, trial subtract)
// Rev 1.0
// ----------------------------------------------------------------------------
module bsg_div_iterative_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem_i,
  input  logic               dvd_msb_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p-1:0] rem_o,
  output logic               q_bit_o
);

  // The shifted partial remainder needs one extra bit: a divisor above
  // 2^(width_p-1) can leave a remainder whose msb is set.
  logic [width_p:0] partial;

  always_comb begin
    partial = {rem_i, dvd_msb_i};
    q_bit_o = (partial >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? (partial[width_p-1:0] - divisor_i) : partial[width_p-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/bsg_div_iterative_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bsg_div_iterative_seq : sequential signed/unsigned restoring divider
// Rev 1.0
// ----------------------------------------------------------------------------
module bsg_div_iterative_seq
  import bsg_div_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,
  output logic               v_o,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  input  logic               yumi_i
);

  localparam int CNT_W = $clog2(width_p + 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0] dvd_q, dvd_d;
  logic [width_p-1:0] rem_q, rem_d;
  logic [width_p-1:0] dvs_q, dvs_d;
  logic               sign_dvd_q, sign_dvd_d;
  logic               sign_dvs_q, sign_dvs_d;

  logic               in_sign_dvd;
  logic               in_sign_dvs;
  logic [width_p-1:0] step_rem;
  logic               step_q_bit;

  bsg_div_iterative_step #(
    .width_p (width_p)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[width_p-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    sign_dvd_d = sign_dvd_q;
    sign_dvs_d = sign_dvs_q;

    in_sign_dvd = signed_i & dividend_i[width_p-1];
    in_sign_dvs = signed_i & divisor_i[width_p-1];

    ready_o = (state_q == eIDLE);
    v_o     = (state_q == eDONE);

    unique case (state_q)
      eIDLE: begin
        if (v_i) begin
          // Magnitudes are treated as unsigned, so |MIN| = 2^(width_p-1) is exact.
          dvd_d      = in_sign_dvd ? -dividend_i : dividend_i;
          dvs_d      = in_sign_dvs ? -divisor_i  : divisor_i;
          sign_dvd_d = in_sign_dvd;
          sign_dvs_d = in_sign_dvs;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = eCALC;
        end
      end
      eCALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[width_p-2:0], step_q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(width_p - 1)) begin
          state_d = eFIX;
        end
      end
      eFIX: begin
        // A zero divisor keeps the all-ones quotient regardless of signs.
        if ((sign_dvd_q ^ sign_dvs_q) && (dvs_q != '0)) begin
          dvd_d = -dvd_q;
        end
        if (sign_dvd_q) begin
          rem_d = -rem_q;
        end
        state_d = eDONE;
      end
      eDONE: begin
        if (yumi_i) begin
          state_d = eIDLE;
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eIDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      sign_dvd_q <= sign_dvd_d;
      sign_dvs_q <= sign_dvs_d;
    end
  end

  assign quotient_o  = dvd_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire
